// File: rtl/rsa_modexp_if.sv
// Request/result bundle for the modular-exponentiation engine: level go/done
// handshake, operands in, result and status out.
interface rsa_modexp_if #(
  parameter int WIDTH = 4096
);
  logic             go;
  logic [WIDTH-1:0] message;
  logic [WIDTH-1:0] exponent;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] cypher;
  logic             done;
  logic             busy;
  logic             error;

  modport master (
    output go, message, exponent, modulus,
    input  cypher, done, busy, error
  );

  modport slave (
    input  go, message, exponent, modulus,
    output cypher, done, busy, error
  );
endinterface

// File: rtl/rsa_modexp.sv
// Left-to-right square-and-multiply modular exponentiation built on a
// bit-serial interleaved modular multiplier (one multiplier bit per cycle).
module rsa_modexp #(
  parameter int WIDTH = 4096
) (
  input  logic           clk,
  input  logic           reset,
  rsa_modexp_if.slave    bus
);

  localparam int EW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REDUCE,
    S_SCAN,
    S_SQUARE,
    S_MULT,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mod_q;
  logic [WIDTH-1:0] ebits;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] base;
  logic [WIDTH+1:0] acc;
  logic [EW-1:0]    mcnt;
  logic [EW-1:0]    epos;
  logic [WIDTH-1:0] cypher_q;
  logic             done_q;
  logic             busy_q;
  logic             error_q;

  logic [WIDTH+1:0] acc_nxt;
  logic [WIDTH-1:0] prod;
  logic             mul_last;
  logic             in_run;

  // One interleaved step: acc = 2*acc mod m, then optionally + a mod m.
  // With acc < m and a < m every intermediate stays below 2m, so two extra
  // bits of headroom are enough and a single conditional subtract suffices.
  function automatic logic [WIDTH+1:0] mod_step(
    input logic [WIDTH+1:0] p,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] m,
    input logic             b
  );
    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] mx;
    mx = {2'b00, m};
    t  = {p[WIDTH:0], 1'b0};
    if (t >= mx) t = t - mx;
    if (b) begin
      t = t + {2'b00, a};
      if (t >= mx) t = t - mx;
    end
    return t;
  endfunction

  assign acc_nxt  = mod_step(acc, mul_a, mod_q, mul_b[WIDTH-1]);
  assign prod     = acc_nxt[WIDTH-1:0];
  assign mul_last = (mcnt == '0);
  assign in_run   = (state != S_IDLE) && (state != S_DONE);

  // Data registers carry no reset; only control and the visible outputs do.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cypher_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
      mcnt     <= '0;
      epos     <= '0;
    end else if (in_run && !bus.go) begin
      state   <= S_IDLE;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.go) begin
            mod_q  <= bus.modulus;
            ebits  <= bus.exponent;
            mul_a  <= WIDTH'(1);
            mul_b  <= bus.message;
            busy_q <= 1'b1;
            state  <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (mod_q == '0 || mod_q == WIDTH'(1)) begin
            error_q  <= (mod_q == '0);
            cypher_q <= '0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= S_DONE;
          end else begin
            acc   <= '0;
            mcnt  <= EW'(WIDTH - 1);
            state <= S_REDUCE;
          end
        end

        // base = 1 * message mod M, which also folds message >= M back in range
        S_REDUCE: begin
          acc   <= acc_nxt;
          mul_b <= mul_b << 1;
          mcnt  <= mcnt - 1'b1;
          if (mul_last) begin
            base  <= prod;
            epos  <= EW'(WIDTH - 1);
            state <= S_SCAN;
          end
        end

        // epos tracks the index of ebits' MSB; once the leading one is found
        // it becomes the count of exponent bits still to process.
        S_SCAN: begin
          if (ebits[WIDTH-1]) begin
            if (epos == '0) begin
              cypher_q <= base;
              error_q  <= 1'b0;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state    <= S_DONE;
            end else begin
              ebits <= ebits << 1;
              mul_a <= base;
              mul_b <= base;
              acc   <= '0;
              mcnt  <= EW'(WIDTH - 1);
              state <= S_SQUARE;
            end
          end else if (epos == '0) begin
            cypher_q <= WIDTH'(1);
            error_q  <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= S_DONE;
          end else begin
            ebits <= ebits << 1;
            epos  <= epos - 1'b1;
          end
        end

        S_SQUARE: begin
          acc   <= acc_nxt;
          mul_b <= mul_b << 1;
          mcnt  <= mcnt - 1'b1;
          if (mul_last) begin
            if (ebits[WIDTH-1]) begin
              mul_a <= base;
              mul_b <= prod;
              acc   <= '0;
              mcnt  <= EW'(WIDTH - 1);
              state <= S_MULT;
            end else if (epos == EW'(1)) begin
              cypher_q <= prod;
              error_q  <= 1'b0;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state    <= S_DONE;
            end else begin
              ebits <= ebits << 1;
              epos  <= epos - 1'b1;
              mul_a <= prod;
              mul_b <= prod;
              acc   <= '0;
              mcnt  <= EW'(WIDTH - 1);
            end
          end
        end

        S_MULT: begin
          acc   <= acc_nxt;
          mul_b <= mul_b << 1;
          mcnt  <= mcnt - 1'b1;
          if (mul_last) begin
            if (epos == EW'(1)) begin
              cypher_q <= prod;
              error_q  <= 1'b0;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state    <= S_DONE;
            end else begin
              ebits <= ebits << 1;
              epos  <= epos - 1'b1;
              mul_a <= prod;
              mul_b <= prod;
              acc   <= '0;
              mcnt  <= EW'(WIDTH - 1);
              state <= S_SQUARE;
            end
          end
        end

        S_DONE: begin
          if (!bus.go) begin
            done_q <= 1'b0;
            state  <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cypher = cypher_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.error  = error_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed bench for rsa_modexp at WIDTH=16 with hand-computed results and
// exact done latencies.
module tb_rsa_modexp;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  rsa_modexp_if #(.WIDTH(W)) bus();
  rsa_modexp #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Issues one request and counts edges after the accepting edge until done.
  task automatic run_req(input logic [W-1:0] m, input logic [W-1:0] e,
                         input logic [W-1:0] n, input bit scramble,
                         output int edges, output bit busy_ok);
    @(negedge clk);
    bus.message  = m;
    bus.exponent = e;
    bus.modulus  = n;
    bus.go       = 1'b1;
    @(posedge clk); #1;
    busy_ok = (bus.busy === 1'b1);
    if (scramble) begin
      bus.message  = W'($urandom);
      bus.exponent = W'($urandom);
      bus.modulus  = W'($urandom);
    end
    edges = 0;
    while (bus.done !== 1'b1 && edges < 2000) begin
      @(posedge clk); #1;
      edges++;
      if (bus.done !== 1'b1 && bus.busy !== 1'b1) busy_ok = 0;
      if (bus.done === 1'b1 && bus.busy !== 1'b0) busy_ok = 0;
    end
  endtask

  task automatic drop_go();
    @(negedge clk);
    bus.go = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.go = 1'b0; bus.message = '0; bus.exponent = '0; bus.modulus = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.cypher, bus.done, bus.busy, bus.error} !== {W'(0), 3'b000}) begin
      miscompares++;
      $display("FAIL reset_outputs: got cypher=%0d done=%b busy=%b error=%b, need all 0",
               bus.cypher, bus.done, bus.busy, bus.error);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int edges; bit bok;
    run_req(16'd8, 16'd13, 16'd77, 0, edges, bok);
    vectors++;
    if (bus.cypher !== 16'd50) begin miscompares++; $display("FAIL basic_cypher: got %0d need 50", bus.cypher); end
    vectors++;
    if (edges !== 110) begin miscompares++; $display("FAIL basic_latency: got %0d need 110", edges); end
    vectors++;
    if (bus.error !== 1'b0) begin miscompares++; $display("FAIL basic_error: got %b need 0", bus.error); end
    vectors++;
    if (bok !== 1'b1) begin miscompares++; $display("FAIL basic_busy: busy profile wrong"); end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.done, bus.cypher} !== {1'b1, 16'd50}) begin
      miscompares++;
      $display("FAIL done_hold: got done=%b cypher=%0d need 1/50", bus.done, bus.cypher);
    end
    drop_go();
    vectors++;
    if (bus.done !== 1'b0) begin miscompares++; $display("FAIL done_release: got %b need 0", bus.done); end
  endtask

  task automatic test_decrypt();
    int edges; bit bok;
    run_req(16'd50, 16'd37, 16'd77, 0, edges, bok);
    vectors++;
    if ({bus.cypher, edges} !== {16'd8, 140}) begin
      miscompares++; $display("FAIL decrypt: got %0d after %0d edges need 8 after 140", bus.cypher, edges);
    end
    drop_go();
    run_req(16'd85, 16'd1, 16'd77, 0, edges, bok);
    vectors++;
    if ({bus.cypher, edges} !== {16'd8, 33}) begin
      miscompares++; $display("FAIL reduce_msg: got %0d after %0d edges need 8 after 33", bus.cypher, edges);
    end
    drop_go();
  endtask

  task automatic test_boundaries();
    int edges; bit bok;
    run_req(16'd8, 16'd0, 16'd77, 0, edges, bok);
    vectors++;
    if ({bus.cypher, edges} !== {16'd1, 33}) begin
      miscompares++; $display("FAIL exp_zero: got %0d after %0d edges need 1 after 33", bus.cypher, edges);
    end
    drop_go();
    run_req(16'd9, 16'd5, 16'd1, 0, edges, bok);
    vectors++;
    if ({bus.cypher, bus.error, edges, bok} !== {16'd0, 1'b0, 1, 1'b1}) begin
      miscompares++; $display("FAIL mod_one: got %0d err=%b after %0d edges busy_ok=%b need 0/0/1/1",
                              bus.cypher, bus.error, edges, bok);
    end
    drop_go();
    run_req(16'd9, 16'd5, 16'd0, 0, edges, bok);
    vectors++;
    if ({bus.cypher, bus.error, edges} !== {16'd0, 1'b1, 1}) begin
      miscompares++; $display("FAIL mod_zero: got %0d err=%b after %0d edges need 0/1/1",
                              bus.cypher, bus.error, edges);
    end
    drop_go();
    run_req(16'd3, 16'd5, 16'd100, 0, edges, bok);
    vectors++;
    if ({bus.cypher, bus.error, edges} !== {16'd43, 1'b0, 79}) begin
      miscompares++; $display("FAIL even_mod: got %0d err=%b after %0d edges need 43/0/79",
                              bus.cypher, bus.error, edges);
    end
    drop_go();
    run_req(16'hFFFE, 16'd2, 16'hFFFF, 0, edges, bok);
    vectors++;
    if ({bus.cypher, edges} !== {16'd1, 48}) begin
      miscompares++; $display("FAIL wide_mod: got %0d after %0d edges need 1 after 48", bus.cypher, edges);
    end
    drop_go();
  endtask

  task automatic test_input_hold();
    int edges; bit bok;
    run_req(16'd50, 16'd37, 16'd77, 1, edges, bok);
    vectors++;
    if ({bus.cypher, edges} !== {16'd8, 140}) begin
      miscompares++; $display("FAIL input_hold: got %0d after %0d edges need 8 after 140", bus.cypher, edges);
    end
    drop_go();
  endtask

  task automatic test_abort();
    int edges; bit bok; bit saw_done;
    run_req(16'd8, 16'd13, 16'd77, 0, edges, bok);
    drop_go();
    @(negedge clk);
    bus.message = 16'd3; bus.exponent = 16'd5; bus.modulus = 16'd100; bus.go = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    vectors++;
    if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL abort_midrun_busy: got %b need 1", bus.busy); end
    drop_go();
    vectors++;
    if ({bus.busy, bus.done, bus.error, bus.cypher} !== {3'b000, 16'd50}) begin
      miscompares++; $display("FAIL abort: got busy=%b done=%b err=%b cypher=%0d need 0/0/0/50",
                              bus.busy, bus.done, bus.error, bus.cypher);
    end
    saw_done = 0;
    repeat (120) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0) saw_done = 1;
    end
    vectors++;
    if (saw_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done: done rose after abort, need never"); end
  endtask

  task automatic test_reset_midrun();
    int edges; bit bok;
    @(negedge clk);
    bus.message = 16'd8; bus.exponent = 16'd13; bus.modulus = 16'd77; bus.go = 1'b1;
    repeat (31) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    vectors++;
    if ({bus.cypher, bus.done, bus.busy, bus.error} !== {W'(0), 3'b000}) begin
      miscompares++; $display("FAIL reset_midrun: got cypher=%0d done=%b busy=%b error=%b need all 0",
                              bus.cypher, bus.done, bus.busy, bus.error);
    end
    @(negedge clk);
    bus.go = 1'b0;
    reset = 1'b0;
    run_req(16'd3, 16'd5, 16'd100, 0, edges, bok);
    vectors++;
    if ({bus.cypher, edges} !== {16'd43, 79}) begin
      miscompares++; $display("FAIL after_reset: got %0d after %0d edges need 43 after 79", bus.cypher, edges);
    end
    drop_go();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decrypt();
    test_boundaries();
    test_input_hold();
    test_abort();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rsa_modexp.md
# rsa_modexp

Parametrised modular-exponentiation engine computing cypher = message^exponent mod modulus for any operand width. It is the next-generation core behind the 4096-bit RSA top and keeps that top's go/done level handshake. New behaviour:
- arbitrary WIDTH
- any modulus ≥ 2, no odd-modulus restriction
- internal reduction of message ≥ modulus
- leading-zero exponent skip
- abort on go drop
- error flag and busy status

## Interface
- WIDTH, 4096: operand and result width in bits; must be ≥ 4.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- go  input  1  level request; sampled in IDLE; must stay high until done.
- message  input  WIDTH  base; any value, reduced internally.
- exponent  input  WIDTH  exponent.
- modulus  input  WIDTH  modulus.
- cypher  output  WIDTH  result register.
- done  output  1  result valid; high until go falls.
- busy  output  1  high from the cycle after go is accepted until done or abort.
- error  output  1  modulus == 0 on the last accepted request; valid while done.

## Operation
- **Operand latch:** message, exponent and modulus are latched on the edge that accepts go. Input changes while busy are ignored.
- **Modular multiply (interleaved, radix-2):** P = A·B mod M, precondition A < M.
  - P starts at 0.
  - For i = WIDTH-1 down to 0, one bit per cycle: P = 2P, subtract M if P ≥ M; then if B[i], P = P + A, subtract M if P ≥ M.
  - Exactly WIDTH cycles per multiply.
  - Internal P is WIDTH+2 bits; the result is always < M.
- **States:**
  - IDLE: wait for go=1, then latch operands and go to CHECK.
  - CHECK (1 cycle):
    - modulus==0: error=1, cypher=0, go to DONE.
    - modulus==1: cypher=0, go to DONE.
    - otherwise: go to REDUCE.
  - REDUCE (WIDTH cycles): base = 1·message mod M, using A=1 and B=message.
  - SCAN (1 cycle per bit, from bit WIDTH-1 downward): stop at the first set exponent bit h and set R = base.
    - If no bit is set, R = 1 and go to DONE.
    - If h == 0, go to DONE.
    - Otherwise go to SQUARE.
  - SQUARE (WIDTH cycles): R = R·R mod M. Then look at the next lower bit j: if set go to MULT, else go to the next SQUARE, or to DONE once bit 0 has been processed.
  - MULT (WIDTH cycles): R = R·base mod M, then continue as above.
  - DONE: cypher = R (or 0 per CHECK); done=1, busy=0.
    - Stays in DONE while go=1.
    - go=0 returns to IDLE; done falls on that same edge.
- **Abort:** go=0 in any busy state returns to IDLE on the next edge. cypher keeps its previous value, done is never asserted, and error is cleared.
- **Reset (any time, including mid-operation):** state=IDLE; cypher=0, done=0, busy=0, error=0.

## Timing
- Let edge 0 be the edge that accepts go. Let h = index of the exponent MSB and p = popcount(exponent[h-1:0]).
- done is high after edge N, where:
  - N = 1 + WIDTH + (WIDTH − h) + WIDTH·(h + p) for exponent ≠ 0 and modulus ≥ 2.
  - N = 1 + 2·WIDTH for exponent == 0.
  - N = 1 for modulus ∈ {0, 1}.
- cypher, done and error update on the same edge. cypher is stable whenever done=1.
- busy rises after edge 0 and falls on the same edge that done rises.
- The earliest new request is accepted on the edge after go has been seen low in IDLE; there is no back-to-back start without a go low cycle.
- Throughput is one result per request; there is no pipelining.

## Test plan
- WIDTH=16, message=8, exponent=13, modulus=77 → cypher=50 (0x0032), done after exactly 110 edges, error=0, busy high for the whole interval.
- Decrypt with message=50, exponent=37, modulus=77 → cypher=8. Then message=85 (≥ modulus), exponent=1, modulus=77 → cypher=8.
- Boundaries:
  - exponent=0, modulus=77 → cypher=1 after 33 edges.
  - modulus=1 → cypher=0, error=0, after 1 edge.
  - modulus=0 → cypher=0, error=1, after 1 edge.
  - Even modulus: message=3, exponent=5, modulus=100 → cypher=43.
- Abort and reset: drop go 20 cycles into a 16-bit run → busy=0 next edge, done never rises, cypher holds 50 from the prior run. Assert reset mid-run → all outputs 0 immediately; a following request completes correctly.
- WIDTH=4096 with the NIST vector (e=0xf3e7af, 2048-bit modulus) → decrypting the cypher with the matching private exponent returns the original message. Changing inputs while busy does not alter the result.
